lock_code_scanner: RTL



---
 rtl/lock_code_scanner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lock_code_scanner.sv
// Sweeps nonzero candidate codes into the LFSR lock core and counts accepted codes until a hit target is reached.
// Latency: match is judged on the code driven this cycle; the next code, hit count and state follow on the next edge.
// Backpressure: none; presents one code per cycle in SCAN, abort returns to IDLE on the next edge.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, abort      run control (start pulse honoured outside SCAN; abort level, any state)
//   hit_target        accepted codes required to finish, captured on an accepted start
//   match             combinational compare result from the lock core for the current code
//   code              registered candidate code driven to the core
//   busy/done/fail    decoded from the registered state
//   hits, last_code   accepted-code count and most recent accepted code
//   attempts          codes presented this run, saturating
module lock_code_scanner #(
    parameter int CODE_W = 15,
    parameter int HIT_W  = 12,
    parameter int ATT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [HIT_W-1:0]  hit_target,
    input  logic              match,
    output logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [HIT_W-1:0]  hits,
    output logic [CODE_W-1:0] last_code,
    output logic [ATT_W-1:0]  attempts
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t              r_state;
    logic [CODE_W-1:0]   r_code;
    logic [HIT_W-1:0]    r_hits;
    logic [CODE_W-1:0]   r_last;
    logic [ATT_W-1:0]    r_att;
    logic [HIT_W-1:0]    r_tgt;

    state_t              w_state;
    logic [CODE_W-1:0]   w_code;
    logic [HIT_W-1:0]    w_hits;
    logic [CODE_W-1:0]   w_last;
    logic [ATT_W-1:0]    w_att;
    logic [HIT_W-1:0]    w_tgt;

    logic [HIT_W-1:0]    w_hits_inc;
    logic [ATT_W-1:0]    w_att_sat;
    logic                w_code_last;

    assign w_hits_inc  = r_hits + HIT_W'(1);
    // Attempts stick at all-ones instead of wrapping back to zero.
    assign w_att_sat   = (&r_att) ? r_att : (r_att + ATT_W'(1));
    // All-ones is the final nonzero value of a sweep.
    assign w_code_last = &r_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_hits  <= '0;
            r_last  <= '0;
            r_att   <= '0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state;
            r_code  <= w_code;
            r_hits  <= w_hits;
            r_last  <= w_last;
            r_att   <= w_att;
            r_tgt   <= w_tgt;
        end
    end

    always_comb begin
        w_state = r_state;
        w_code  = r_code;
        w_hits  = r_hits;
        w_last  = r_last;
        w_att   = r_att;
        w_tgt   = r_tgt;

        if (abort) begin
            // Counters and last_code are kept so a stalled run can be inspected.
            w_state = ST_IDLE;
            w_code  = '0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    w_att = w_att_sat;
                    if (match) begin
                        // The core's secret steps on this same edge, so the sweep restarts from 1.
                        w_hits = w_hits_inc;
                        w_last = r_code;
                        w_code = CODE_W'(1);
                        if (w_hits_inc == r_tgt) begin
                            w_state = ST_DONE;
                        end
                    end else if (w_code_last) begin
                        // Whole nonzero space tried without a hit; code stays at all-ones.
                        w_state = ST_FAIL;
                    end else begin
                        w_code = r_code + CODE_W'(1);
                    end
                end
                default: begin
                    // IDLE, DONE and FAIL all wait for a fresh start; match is ignored here.
                    if (start) begin
                        w_hits = '0;
                        w_att  = '0;
                        w_tgt  = hit_target;
                        if (hit_target == '0) begin
                            w_state = ST_DONE;
                        end else begin
                            w_code  = CODE_W'(1);
                            w_state = ST_SCAN;
                        end
                    end
                end
            endcase
        end
    end

    assign code      = r_code;
    assign busy      = (r_state == ST_SCAN);
    assign done      = (r_state == ST_DONE);
    assign fail      = (r_state == ST_FAIL);
    assign hits      = r_hits;
    assign last_code = r_last;
    assign attempts  = r_att;

endmodule
